// File: rtl/tlc_mon_pkg.sv
// Shared types for the traffic-light output monitor.
// Phase, fault-cause and lamp encodings plus phase-order helpers.
package tlc_mon_pkg;

    typedef enum logic [2:0] {
        PH_NS_G  = 3'd0,
        PH_NS_Y  = 3'd1,
        PH_AR1   = 3'd2,
        PH_EW_G  = 3'd3,
        PH_EW_Y  = 3'd4,
        PH_AR2   = 3'd5,
        PH_FAULT = 3'd6,
        PH_HUNT  = 3'd7
    } phase_e;

    typedef enum logic [2:0] {
        FC_NONE     = 3'd0,
        FC_ENC      = 3'd1,
        FC_CONFLICT = 3'd2,
        FC_SEQ      = 3'd3,
        FC_TIMING   = 3'd4
    } fcode_e;

    typedef enum logic [2:0] {
        RAW_NS_G   = 3'd0,
        RAW_NS_Y   = 3'd1,
        RAW_EW_G   = 3'd2,
        RAW_EW_Y   = 3'd3,
        RAW_ALLRED = 3'd4
    } raw_e;

    localparam logic [2:0] LAMP_G = 3'b001;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b100;

    // Lamp pattern a tracked phase shows; both all-red phases look alike.
    function automatic raw_e phase_lamps(input phase_e p);
        case (p)
            PH_NS_G: phase_lamps = RAW_NS_G;
            PH_NS_Y: phase_lamps = RAW_NS_Y;
            PH_EW_G: phase_lamps = RAW_EW_G;
            PH_EW_Y: phase_lamps = RAW_EW_Y;
            default: phase_lamps = RAW_ALLRED;
        endcase
    endfunction

    // Legal successor in the locked cycle.
    function automatic phase_e phase_succ(input phase_e p);
        case (p)
            PH_NS_G: phase_succ = PH_NS_Y;
            PH_NS_Y: phase_succ = PH_AR1;
            PH_AR1:  phase_succ = PH_EW_G;
            PH_EW_G: phase_succ = PH_EW_Y;
            PH_EW_Y: phase_succ = PH_AR2;
            default: phase_succ = PH_NS_G;
        endcase
    endfunction

    // Phase to lock onto from HUNT; all-red is ambiguous and stays HUNT.
    function automatic phase_e raw_to_phase(input raw_e r);
        case (r)
            RAW_NS_G: raw_to_phase = PH_NS_G;
            RAW_NS_Y: raw_to_phase = PH_NS_Y;
            RAW_EW_G: raw_to_phase = PH_EW_G;
            RAW_EW_Y: raw_to_phase = PH_EW_Y;
            default:  raw_to_phase = PH_HUNT;
        endcase
    endfunction

endpackage

// File: rtl/tlc_light_decode.sv
// Combinational lamp decoder for the monitor.
// Flags bad encodings and conflicts and classifies the lamp pair.
module tlc_light_decode
    import tlc_mon_pkg::*;
(
    input  logic [2:0] N_S,
    input  logic [2:0] E_W,
    output logic       enc_err,
    output logic       conflict,
    output raw_e       raw_phase
);

    logic ns_oh;
    logic ew_oh;

    assign ns_oh    = (N_S == LAMP_G) || (N_S == LAMP_Y) || (N_S == LAMP_R);
    assign ew_oh    = (E_W == LAMP_G) || (E_W == LAMP_Y) || (E_W == LAMP_R);
    assign enc_err  = !ns_oh || !ew_oh;
    assign conflict = (N_S != LAMP_R) && (E_W != LAMP_R);

    // Classify the lamp pair; only meaningful when neither error is set.
    always_comb begin
        raw_phase = RAW_ALLRED;
        unique case (1'b1)
            (N_S == LAMP_G) && (E_W == LAMP_R): raw_phase = RAW_NS_G;
            (N_S == LAMP_Y) && (E_W == LAMP_R): raw_phase = RAW_NS_Y;
            (N_S == LAMP_R) && (E_W == LAMP_G): raw_phase = RAW_EW_G;
            (N_S == LAMP_R) && (E_W == LAMP_Y): raw_phase = RAW_EW_Y;
            default:                            raw_phase = RAW_ALLRED;
        endcase
    end

endmodule

// File: rtl/tlc_monitor.sv
// Safety/compliance monitor on the traffic-light lamp outputs.
// Tracks phase order and dwell, latches the first violation.
module tlc_monitor
    import tlc_mon_pkg::*;
#(
    parameter int unsigned T_GREEN  = 16,
    parameter int unsigned T_YELLOW = 3,
    parameter int unsigned T_ALLRED = 3,
    parameter int unsigned TOL      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] N_S,
    input  logic [2:0] E_W,
    input  logic       clr,
    output logic [2:0] phase,
    output logic       locked,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       cycle_done,
    output logic [7:0] cycle_count
);

    localparam int unsigned G_LO = (T_GREEN  > TOL + 1) ? T_GREEN  - TOL : 1;
    localparam int unsigned Y_LO = (T_YELLOW > TOL + 1) ? T_YELLOW - TOL : 1;
    localparam int unsigned R_LO = (T_ALLRED > TOL + 1) ? T_ALLRED - TOL : 1;

    localparam logic [7:0] G_HI = 8'(T_GREEN + TOL);
    localparam logic [7:0] Y_HI = 8'(T_YELLOW + TOL);
    localparam logic [7:0] R_HI = 8'(T_ALLRED + TOL);

    logic   enc_err;
    logic   conflict;
    raw_e   raw;

    phase_e phase_q, phase_d;
    fcode_e code_q, code_d;
    logic   locked_q, locked_d;
    logic   fault_q, fault_d;
    logic   first_q, first_d;
    logic   done_q, done_d;
    logic [7:0] dwell_q, dwell_d;
    logic [7:0] count_q, count_d;
    logic [7:0] dwell_lo;
    logic [7:0] dwell_hi;
    fcode_e viol;
    phase_e nxt;

    tlc_light_decode u_dec (
        .N_S       (N_S),
        .E_W       (E_W),
        .enc_err   (enc_err),
        .conflict  (conflict),
        .raw_phase (raw)
    );

    // Dwell window for the phase currently being tracked.
    always_comb begin
        dwell_lo = 8'(R_LO);
        dwell_hi = R_HI;
        case (phase_q)
            PH_NS_G, PH_EW_G: begin
                dwell_lo = 8'(G_LO);
                dwell_hi = G_HI;
            end
            PH_NS_Y, PH_EW_Y: begin
                dwell_lo = 8'(Y_LO);
                dwell_hi = Y_HI;
            end
            default: ;
        endcase
    end

    // Next-state: lock, track order/dwell, prioritise and latch faults.
    always_comb begin
        phase_d  = phase_q;
        code_d   = code_q;
        locked_d = locked_q;
        fault_d  = fault_q;
        first_d  = first_q;
        dwell_d  = dwell_q;
        count_d  = count_q;
        done_d   = 1'b0;
        viol     = FC_NONE;
        nxt      = phase_succ(phase_q);
        if (clr) begin
            phase_d  = PH_HUNT;
            code_d   = FC_NONE;
            locked_d = 1'b0;
            fault_d  = 1'b0;
            first_d  = 1'b0;
            dwell_d  = 8'd0;
        end else if (phase_q != PH_FAULT) begin
            if (enc_err) begin
                viol = FC_ENC;
            end else if (conflict) begin
                viol = FC_CONFLICT;
            end else if (phase_q == PH_HUNT) begin
                if (raw != RAW_ALLRED) begin
                    phase_d  = raw_to_phase(raw);
                    locked_d = 1'b1;
                    first_d  = 1'b1;
                    dwell_d  = 8'd1;
                end
            end else if (raw == phase_lamps(phase_q)) begin
                if (dwell_q >= dwell_hi) begin
                    viol = FC_TIMING;
                end else if (dwell_q != 8'hFF) begin
                    dwell_d = dwell_q + 8'd1;
                end
            end else if (raw == phase_lamps(nxt)) begin
                if (!first_q && (dwell_q < dwell_lo)) begin
                    viol = FC_TIMING;
                end else begin
                    phase_d = nxt;
                    first_d = 1'b0;
                    dwell_d = 8'd1;
                    if (phase_q == PH_AR2) begin
                        done_d  = 1'b1;
                        count_d = count_q + 8'd1;
                    end
                end
            end else begin
                viol = FC_SEQ;
            end
            if (viol != FC_NONE) begin
                phase_d  = PH_FAULT;
                code_d   = viol;
                fault_d  = 1'b1;
                locked_d = 1'b0;
                done_d   = 1'b0;
                count_d  = count_q;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q  <= PH_HUNT;
            code_q   <= FC_NONE;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
            first_q  <= 1'b0;
            done_q   <= 1'b0;
            dwell_q  <= 8'd0;
            count_q  <= 8'd0;
        end else begin
            phase_q  <= phase_d;
            code_q   <= code_d;
            locked_q <= locked_d;
            fault_q  <= fault_d;
            first_q  <= first_d;
            done_q   <= done_d;
            dwell_q  <= dwell_d;
            count_q  <= count_d;
        end
    end

    assign phase       = phase_q;
    assign locked      = locked_q;
    assign fault       = fault_q;
    assign fault_code  = code_q;
    assign cycle_done  = done_q;
    assign cycle_count = count_q;

endmodule

// File: doc/tlc_monitor.md
Name: tlc_monitor

Overview:
- Independent safety and compliance checker on the light-output side of the traffic-light controller.
- Samples the N_S/E_W lamp drive every clock, decodes the current phase, and tracks the expected phase order and per-phase dwell time.
- Latches the first violation as a sticky fault with a cause code; the fault stays until cleared.
- Sits beside the controller; its outputs feed the fault-handling/flash-mode logic.

Parameters:
- T_GREEN, 16, expected green dwell in clocks (both directions).
- T_YELLOW, 3, expected yellow dwell in clocks.
- T_ALLRED, 3, expected all-red dwell in clocks.
- TOL, 1, allowed ± deviation on every dwell; lower bound clamps at 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- N_S  in  3  north-south lamps, one-hot: 001 green, 010 yellow, 100 red.
- E_W  in  3  east-west lamps, same encoding.
- clr  in  1  synchronous fault clear; returns monitor to HUNT.
- phase  out  3  decoded phase: 0 NS_G, 1 NS_Y, 2 AR1, 3 EW_G, 4 EW_Y, 5 AR2, 6 FAULT, 7 HUNT.
- locked  out  1  high while tracking a legal sequence.
- fault  out  1  sticky violation flag.
- fault_code  out  3  0 NONE, 1 ENC, 2 CONFLICT, 3 SEQ, 4 TIMING.
- cycle_done  out  1  one-clock pulse per completed full cycle.
- cycle_count  out  8  completed cycles, wraps 255→0.

Behaviour:
- Clock and reset:
  - Single clock domain; reset is synchronous and active-low.
  - rst=0 at an edge sets phase=HUNT, locked=0, fault=0, fault_code=0, cycle_done=0, cycle_count=0, dwell=0.
- Timing: all outputs are registered. A sample taken at edge k is reflected in the outputs after edge k (1-cycle latency).
- Checks evaluated on each sample, highest priority first:
  - ENC: either input not one-hot.
  - CONFLICT: neither direction red.
  - SEQ: illegal phase change.
  - TIMING: dwell out of range.
- ENC and CONFLICT are checked in every state except FAULT. SEQ and TIMING are checked only while locked.
- HUNT:
  - All-red samples keep the monitor in HUNT, since AR1 and AR2 are ambiguous there.
  - The first legal non-all-red phase locks the monitor: locked=1, dwell=1.
  - The dwell of this first phase is exempt from the underrun check but not from the overrun check.
- Locked order: NS_G→NS_Y→AR1→EW_G→EW_Y→AR2→NS_G.
  - All-red after NS_Y decodes as AR1; all-red after EW_Y decodes as AR2.
  - Any other change of decoded lamps raises SEQ. This includes a skip, a reversal, or a green returning directly.
- Dwell counter:
  - 8-bit, saturating at 255.
  - Increments on each sample in the same phase; set to 1 on entering a new phase.
- TIMING, with T being the expected dwell for the current phase:
  - Overrun: flagged on the sample that would make dwell = T+TOL+1.
  - Underrun: flagged on the first sample of the next phase if the exiting dwell < max(1, T−TOL).
- Cycle count: entering NS_G from AR2 while locked pulses cycle_done for one clock and increments cycle_count.
- Fault latch:
  - The first violation sets fault=1, fault_code to the winning cause, phase=FAULT, locked=0.
  - Further violations are ignored and fault_code is held.
  - cycle_count is held while in FAULT.
- clr:
  - clr=1 at an edge clears fault/fault_code and returns to HUNT (dwell=0); cycle_count is unchanged.
  - clr wins over a violation detected at the same edge.
  - clr while not faulted also forces HUNT.
- Reset mid-cycle or mid-fault behaves identically to power-up reset.

Decomposition:
- Shared package tlc_mon_pkg holds:
  - phase codes (3-bit);
  - fault codes (3-bit);
  - lamp encodings LAMP_G=3'b001, LAMP_Y=3'b010, LAMP_R=3'b100.
- One natural combinational sub-module, tlc_light_decode: maps {N_S,E_W} to {enc_err, conflict, raw_phase}.
  - raw_phase values: NS_G, NS_Y, EW_G, EW_Y, ALL_RED.
  - The FSM, dwell counter and fault latch live in tlc_monitor.

Test Plan:
- Reset: hold rst=0 for 2 clocks with garbage inputs → phase=7, locked=0, fault=0, fault_code=0, cycle_count=0.
- Legal stream: NS_G×16, NS_Y×3, AR×3, EW_G×16, EW_Y×3, AR×3, NS_G → no fault; locked=1 after the first sample; cycle_done pulses one clock after the NS_G entry sample; cycle_count=1.
- Conflict/encoding:
  - While locked in EW_G, drive N_S=001 → next clock fault=1, fault_code=2, phase=6.
  - With rst, repeat using E_W=011 together with N_S=001 → fault_code=1 (ENC beats CONFLICT).
- Timing:
  - Hold NS_Y for 5 samples → TIMING (4) on the 5th sample.
  - Separate run: NS_Y for 1 sample then all-red → TIMING on the all-red sample.
- Sequence: NS_Y×3 followed directly by N_S=100, E_W=001 → fault_code=3. Then a second violation → code stays 3.
- Clear:
  - With fault latched, assert clr together with a new conflict → fault=0, phase=7.
  - Then a legal NS_G → locked=1 and cycle_count unchanged.
